// File: rtl/np_pkg.sv
// np_pkg: shared widths, boot-state encoding and CPU opcodes for the np CPU.
package np_pkg;

    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;
    localparam int MEMSIZE  = 1 << ADDRSIZE;

    typedef enum logic [2:0] {
        LOAD,
        RELEASE,
        RUN,
        HALTED,
        ERROR
    } boot_state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hB;

    function automatic logic [WIDTH-1:0] np_asm(input logic [3:0] op, input logic [WIDTH-5:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/np_sync_ram.sv
// np_sync_ram: single write port, registered read port with enable; a read
// colliding with a write to the same address returns the old word.
module np_sync_ram #(
    parameter int WIDTH    = np_pkg::WIDTH,
    parameter int ADDRSIZE = np_pkg::ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [1 << ADDRSIZE];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb rdata_d = re ? mem[raddr] : rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        rdata_q <= reset ? '0 : rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/np_boot_mem.sv
// np_boot_mem: streams a program into memory, releases the CPU, serves its bus
// and parks it on halt. NP_LOAD_CKSUM_EN makes the last beat a checksum.
module np_boot_mem import np_pkg::*; #(
    parameter int WIDTH    = np_pkg::WIDTH,
    parameter int ADDRSIZE = np_pkg::ADDRSIZE,
    parameter int RST_HOLD = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [WIDTH-1:0]    ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                cpu_reset,
    input  logic [ADDRSIZE-1:0] cpu_addr,
    input  logic                cpu_wr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic [WIDTH-1:0]    cpu_rdata,
    input  logic                cpu_halt,
    output logic [ADDRSIZE:0]   load_count,
    output logic                overflow,
    output logic                done,
    output logic                err
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int CW    = $clog2(RST_HOLD + 1);

    boot_state_t         state_q, state_d;
    logic [ADDRSIZE-1:0] wptr_q, wptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDRSIZE:0]   count_q, count_d;
    logic                ovf_q, ovf_d, ready_q, ready_d, crst_q, crst_d, done_q, done_d;
    logic                acc, store, top, run;

    assign run = state_q == RUN;
    assign acc = state_q == LOAD && ld_valid && ready_q;
    assign top = wptr_q == ADDRSIZE'(DEPTH - 1);

`ifdef NP_LOAD_CKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             err_q, err_d;
    assign store = acc && !ld_last;
    assign err   = err_q;
`else
    assign store = acc;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = store ? wptr_q + 1'b1 : wptr_q;
        count_d = store && count_q != (ADDRSIZE+1)'(DEPTH) ? count_q + 1'b1 : count_q;
        ovf_d   = ovf_q || (acc && top && !ld_last);
        cnt_d   = state_q == RELEASE ? cnt_q + 1'b1 : '0;
        if (acc && (ld_last || top))
            state_d = RELEASE;
`ifdef NP_LOAD_CKSUM_EN
        sum_d = store ? sum_q + ld_data : sum_q;
        if (acc && ld_last && ld_data != sum_q)
            state_d = ERROR;
`endif
        if (state_q == RELEASE && cnt_q == CW'(RST_HOLD)) begin
            state_d = RUN;
            cnt_d   = '0;
        end
        if (run && cpu_halt)
            state_d = HALTED;
        ready_d = state_d == LOAD;
        crst_d  = state_d != RUN;
        done_d  = state_d == HALTED;
`ifdef NP_LOAD_CKSUM_EN
        err_d = state_d == ERROR;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            crst_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef NP_LOAD_CKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            crst_q  <= crst_d;
            done_q  <= done_d;
`ifdef NP_LOAD_CKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    // Loader owns the write port during LOAD, the CPU only while in RUN.
    np_sync_ram #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (!reset && (store || (run && cpu_wr))),
        .waddr (run ? cpu_addr : wptr_q),
        .wdata (run ? cpu_wdata : ld_data),
        .re    (run),
        .raddr (cpu_addr),
        .rdata (cpu_rdata)
    );

    assign ld_ready   = ready_q;
    assign cpu_reset  = crst_q;
    assign load_count = count_q;
    assign overflow   = ovf_q;
    assign done       = done_q;

endmodule

// File: tb/tb_np_boot_mem.sv
// tb_np_boot_mem: randomized loader/CPU stimulus against an array model of
// memory, with a read-data scoreboard drained by a separate monitor.
module tb_np_boot_mem;
    import np_pkg::*;

    localparam int RH = 2;
`ifdef NP_LOAD_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        ld_valid = 1'b0, ld_last = 1'b0, cpu_wr = 1'b0, cpu_halt = 1'b0;
    logic [31:0] ld_data = '0, cpu_wdata = '0;
    logic [11:0] cpu_addr = '0;
    logic        ld_ready, cpu_reset, overflow, done, err;
    logic [31:0] cpu_rdata;
    logic [12:0] load_count;

    int          total = 0, bad = 0;
    logic [31:0] mm [4096];
    logic [31:0] sbq [$];
    logic [31:0] prog [$];
    bit          rd_issue = 1'b0, rd_pend = 1'b0;

    np_boot_mem #(.WIDTH(32), .ADDRSIZE(12), .RST_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .cpu_reset(cpu_reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
        .load_count(load_count), .overflow(overflow), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic miss(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sbq.size() == 0)
                miss("scoreboard_empty");
            else
                chk("cpu_rdata", {32'b0, cpu_rdata}, {32'b0, sbq.pop_front()});
        end
    end

    task automatic do_reset(input string tag);
        reset = 1'b1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        cpu_wr = 1'b0;
        cpu_halt = 1'b0;
        rd_issue = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_ld_ready"}, {63'b0, ld_ready}, 64'd0);
        chk({tag, "_cpu_reset"}, {63'b0, cpu_reset}, 64'd1);
        chk({tag, "_cpu_rdata"}, {32'b0, cpu_rdata}, 64'd0);
        chk({tag, "_load_count"}, {51'b0, load_count}, 64'd0);
        chk({tag, "_overflow"}, {63'b0, overflow}, 64'd0);
        chk({tag, "_done"}, {63'b0, done}, 64'd0);
        chk({tag, "_err"}, {63'b0, err}, 64'd0);
        reset = 1'b0;
    endtask

    // n data words; with the checksum build and last=1 an extra checksum beat follows.
    task automatic load(input int n, input bit last, input bit bursty, input bit corrupt);
        int          i = 0, g = 0;
        logic [31:0] s = '0, d;
        bit          ck, acc;
        while (g < 20000 && i < n + ((last && CK) ? 1 : 0)) begin
            ck = CK && last && i == n;
            d = ck ? s + {31'b0, corrupt} : (i < prog.size() ? prog[i] : $urandom);
            ld_valid = bursty ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_data = d;
            ld_last = last && (CK ? i == n : i == n - 1);
            acc = ld_valid && ld_ready;
            @(posedge clk);
            #1;
            g++;
            if (acc) begin
                if (!ck) begin
                    mm[i] = d;
                    s += d;
                end
                i++;
            end
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        if (g >= 20000)
            miss("load_timeout");
    endtask

    task automatic wait_run(output int k);
        k = 0;
        while (cpu_reset === 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic cpu_op(input logic [11:0] a, input bit wr, input logic [31:0] wd, input bit halt);
        cpu_addr = a;
        cpu_wr = wr;
        cpu_wdata = wd;
        cpu_halt = halt;
        rd_issue = 1'b1;
        sbq.push_back(mm[a]);
        @(posedge clk);
        #1;
        if (wr)
            mm[a] = wd;
        cpu_wr = 1'b0;
        cpu_halt = 1'b0;
        rd_issue = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [31:0] held;
        do_reset("init");

        ld_valid = 1'b1;
        ld_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("midload_count", {51'b0, load_count}, 64'd2);
        do_reset("midload");

        load(4096, 1'b0, 1'b0, 1'b0);
        chk("ovf_flag", {63'b0, overflow}, 64'd1);
        chk("ovf_count", {51'b0, load_count}, 64'd4096);
        wait_run(k);
        chk("ovf_release", 64'(k), 64'(RH + 1));
        for (int i = 0; i < 24; i++)
            cpu_op(12'($urandom_range(0, 4095)), 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;

        do_reset("prog");
        prog = '{32'h2100_5001, 32'h4000_1001, np_asm(OP_HALT, 28'h0)};
        load(3, 1'b1, 1'b1, 1'b0);
        chk("prog_ready_drop", {63'b0, ld_ready}, 64'd0);
        chk("prog_count", {51'b0, load_count}, 64'd3);
        chk("prog_overflow", {63'b0, overflow}, 64'd0);
        wait_run(k);
        chk("prog_release", 64'(k), 64'(RH + 1));
        for (int i = 0; i < 3; i++)
            cpu_op(12'(i), 1'b0, 32'h0, 1'b0);
        cpu_op(12'h010, 1'b1, 32'hDEAD_BEEF, 1'b0);
        cpu_op(12'h010, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++)
            cpu_op(12'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
        held = mm[12'h020];
        cpu_op(12'h020, 1'b1, 32'hC0FF_EE01, 1'b1);
        chk("halt_done", {63'b0, done}, 64'd1);
        chk("halt_cpu_reset", {63'b0, cpu_reset}, 64'd1);
        cpu_addr = 12'h001;
        ld_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        chk("halted_done_held", {63'b0, done}, 64'd1);
        chk("halted_ready", {63'b0, ld_ready}, 64'd0);
        chk("halted_count", {51'b0, load_count}, 64'd3);
        chk("halted_rdata_hold", {32'b0, cpu_rdata}, {32'b0, held});

        do_reset("reload");
        prog = '{};
        load(20, 1'b1, 1'b1, 1'b0);
        chk("reload_count", {51'b0, load_count}, 64'd20);
        wait_run(k);
        chk("reload_release", 64'(k), 64'(RH + 1));
        cpu_op(12'h020, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++)
            cpu_op(12'(i), 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;

`ifdef NP_LOAD_CKSUM_EN
        do_reset("ck_ok");
        prog = '{32'd1, 32'd2};
        load(2, 1'b1, 1'b0, 1'b0);
        chk("ck_ok_count", {51'b0, load_count}, 64'd2);
        wait_run(k);
        chk("ck_ok_release", 64'(k), 64'(RH + 1));
        chk("ck_ok_err", {63'b0, err}, 64'd0);
        cpu_op(12'h000, 1'b0, 32'h0, 1'b0);
        cpu_op(12'h001, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        do_reset("ck_bad");
        load(2, 1'b1, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("ck_bad_err", {63'b0, err}, 64'd1);
        chk("ck_bad_cpu_reset", {63'b0, cpu_reset}, 64'd1);
        chk("ck_bad_ready", {63'b0, ld_ready}, 64'd0);
        chk("ck_bad_count", {51'b0, load_count}, 64'd2);
        do_reset("ck_clear");
`endif

        if (sbq.size() != 0)
            miss("scoreboard_leftover");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/np_boot_mem.md
Name: np_boot_mem

Overview:
Program-load and memory stage for the np 32-bit non-pipelined CPU. Holds the CPU's 2^ADDRSIZE x WIDTH memory and accepts a program over a valid/ready stream, writing consecutive words from address 0. Once loading ends it releases the CPU from reset and serves its memory bus. It then watches the CPU halt signal and parks the CPU back in reset.

Parameters:
WIDTH, 32, data and instruction word width
ADDRSIZE, 12, memory address width; depth MEMSIZE = 1<<ADDRSIZE
RST_HOLD, 2, cycles cpu_reset stays high after loading ends (minimum 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ld_valid  input  1  loader word valid
ld_data  input  WIDTH  loader word
ld_last  input  1  final word of program
ld_ready  output  1  block accepts loader word
cpu_reset  output  1  drives CPU reset
cpu_addr  input  ADDRSIZE  CPU memory address
cpu_wr  input  1  CPU write strobe
cpu_wdata  input  WIDTH  CPU write data
cpu_rdata  output  WIDTH  CPU read data, registered
cpu_halt  input  1  CPU halted
load_count  output  ADDRSIZE+1  program words stored
overflow  output  1  load truncated at top of memory
done  output  1  program ran to halt
err  output  1  checksum failure (optional feature only)

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high. All outputs are registered.
- Reset values: ld_ready=0, cpu_reset=1, cpu_rdata=0, load_count=0, overflow=0, done=0, err=0, state=LOAD, write pointer wptr=0. Memory contents are not cleared.
- States: LOAD, RELEASE, RUN, HALTED, and ERROR (ERROR only with the optional feature).
- LOAD:
  - ld_ready=1 from the first cycle after reset deasserts.
  - A beat is accepted when ld_valid and ld_ready are both high: mem[wptr] <= ld_data, wptr++, load_count++.
  - An accepted beat with ld_last goes to RELEASE, and ld_ready drops the next cycle.
  - An accepted beat at wptr = MEMSIZE-1 without ld_last sets overflow=1, stores the word, and goes to RELEASE.
  - ld_valid without ld_ready is ignored, and ld_data need not be held.
  - The CPU port is ignored: no writes, cpu_rdata holds its value.
- RELEASE:
  - cpu_reset=1 and ld_ready=0.
  - Counter runs RST_HOLD cycles, then cpu_reset falls and the block enters RUN.
- RUN:
  - cpu_wr=1 writes mem[cpu_addr] <= cpu_wdata.
  - cpu_rdata <= mem[cpu_addr] every cycle, with one-cycle latency.
  - A read and write to the same address in the same cycle returns the OLD data.
  - cpu_halt=1 enters HALTED on the next edge. A cpu_wr in that same cycle still commits.
- HALTED:
  - cpu_reset=1, done=1, ld_ready=0, CPU port ignored.
  - Held until reset.
- Simultaneous events: cpu_halt and cpu_wr in the same RUN cycle is covered above. ld_valid is ignored outside LOAD.
- Reset mid-operation (any state): returns to LOAD, wptr=0, and all flags clear.
- load_count saturates at MEMSIZE.

Optional Feature:
NP_LOAD_CKSUM_EN
- Defined:
  - The ld_last beat is a checksum and is not stored, so load_count excludes it.
  - The checksum is the mod-2^WIDTH sum of all stored words.
  - On match, go to RELEASE.
  - On mismatch, go to ERROR: err=1, cpu_reset=1, ld_ready=0, held until reset.
  - An overflow termination skips the check and goes to RELEASE.
- Undefined:
  - The ld_last beat is an ordinary stored word.
  - err is tied 0 and the ERROR state does not exist.

Decomposition:
- Shared package np_pkg:
  - WIDTH, ADDRSIZE, MEMSIZE
  - boot-state enum (LOAD, RELEASE, RUN, HALTED, ERROR)
  - the CPU opcode constants, so benches can assemble programs
- Sub-module np_sync_ram:
  - one write port and one registered read port, depth MEMSIZE
  - the top muxes the write source between loader and CPU by state

Test Plan:
- Load 3 words (0x2100_5001, 0x4000_1001, 0xB000_0000), ld_last on the third -> load_count=3; cpu_reset falls RST_HOLD+1 cycles after the last accept; RUN reads of addresses 0..2 return those words one cycle later.
- Hold ld_valid high and toggle the source between bursts -> only beats with ld_ready high are stored, with no duplicated or skipped addresses.
- In RUN, cpu_wr to addr 0x010 with 0xDEAD_BEEF, then read 0x010 -> the same-cycle read returns old data, the next read returns 0xDEAD_BEEF.
- Assert cpu_halt together with cpu_wr to 0x020 -> write commits, done=1 next cycle, cpu_reset=1.
- Stream 4096 words with no ld_last -> overflow=1, load_count=4096, then RELEASE.
- With NP_LOAD_CKSUM_EN: words 1, 2 then checksum 3 -> RUN; repeat with checksum 4 -> err=1 and cpu_reset stays high. Also assert reset mid-load -> outputs return to their reset values.
